// File: rtl/scale_mux_pkg.sv
// Shared types and default sizes for the scale_mux arbiter slice.
package scale_mux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } prio_t;

endpackage

// File: rtl/scale_mux.sv
// Plain 2:1 payload selector; picks in_a when sel_a is high.
module scale_mux
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sel_a,
    output logic [WIDTH-1:0] out
);

    assign out = sel_a ? in_a : in_b;

endmodule

// File: rtl/scale_mux_arb.sv
// Two-source round-robin arbiter feeding a one-deep registered output stage,
// with saturating per-source grant counters.
//
// state | meaning
// PRI_A | source A wins when both sources are valid
// PRI_B | source B wins when both sources are valid
module scale_mux_arb
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_a,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    prio_t            state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_a_q, sel_a_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             load;
    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] mux_out;

    scale_mux #(.WIDTH(WIDTH)) u_mux (
        .in_a  (a_data),
        .in_b  (b_data),
        .sel_a (grant_a),
        .out   (mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRI_A;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_a_q     <= 1'b0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_a_q     <= sel_a_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_a_d     = sel_a_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;

        // The output slot can take a new beat when empty or being drained now.
        load    = !out_valid_q || out_ready;
        grant_a = !rst && load && a_valid && (!b_valid || state_q == PRI_A);
        grant_b = !rst && load && b_valid && (!a_valid || state_q == PRI_B);

        if (grant_a) begin
            state_d = PRI_B;
            if (cnt_a_q != {CNT_W{1'b1}}) cnt_a_d = cnt_a_q + CNT_W'(1);
        end else if (grant_b) begin
            state_d = PRI_A;
            if (cnt_b_q != {CNT_W{1'b1}}) cnt_b_d = cnt_b_q + CNT_W'(1);
        end

        if (grant_a || grant_b) begin
            out_data_d  = mux_out;
            sel_a_d     = grant_a;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_a     = sel_a_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_scale_mux_arb.sv
// Directed vector bench for scale_mux_arb; a second CNT_W=2 instance
// shares the stimulus so counter saturation can be observed quickly.
module tb_scale_mux_arb;

    logic        clk;
    logic        rst;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, out_ready;
    logic        a_ready, b_ready, out_valid, sel_a;
    logic [7:0]  out_data;
    logic [15:0] cnt_a, cnt_b;

    logic        s_a_ready, s_b_ready, s_out_valid, s_sel_a;
    logic [7:0]  s_out_data;
    logic [1:0]  s_cnt_a, s_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    scale_mux_arb dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_a(sel_a), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    scale_mux_arb #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(s_a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(s_b_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .sel_a(s_sel_a), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [7:0]  ad;
        logic        bv;
        logic [7:0]  bd;
        logic        ordy;
        logic        e_ar;
        logic        e_br;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_sel;
        logic [15:0] e_ca;
        logic [15:0] e_cb;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic r, logic av, logic [7:0] ad, logic bv,
                                logic [7:0] bd, logic ordy, logic ear, logic ebr,
                                logic eov, logic [7:0] eod, logic esel,
                                logic [15:0] eca, logic [15:0] ecb);
        vec_t v;
        v.rst = r;  v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.e_ar = ear; v.e_br = ebr; v.e_ov = eov; v.e_od = eod; v.e_sel = esel;
        v.e_ca = eca; v.e_cb = ecb;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst       = v.rst;
        a_valid   = v.av;
        a_data    = v.ad;
        b_valid   = v.bv;
        b_data    = v.bd;
        out_ready = v.ordy;
        #2;
        chk("a_ready", idx, {31'd0, a_ready}, {31'd0, v.e_ar});
        chk("b_ready", idx, {31'd0, b_ready}, {31'd0, v.e_br});
        @(posedge clk);
        #1;
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v.e_ov});
        chk("out_data", idx, {24'd0, out_data}, {24'd0, v.e_od});
        chk("sel_a", idx, {31'd0, sel_a}, {31'd0, v.e_sel});
        chk("cnt_a", idx, {16'd0, cnt_a}, {16'd0, v.e_ca});
        chk("cnt_b", idx, {16'd0, cnt_b}, {16'd0, v.e_cb});
    endtask

    initial begin
        //               rst av ad     bv bd     ordy ar br ov od     sel ca  cb
        vecs[0]  = mk(1, 1, 8'hAA, 1, 8'h55, 1,  0, 0, 0, 8'h00, 0,  0,  0);
        vecs[1]  = mk(1, 1, 8'hAA, 1, 8'h55, 1,  0, 0, 0, 8'h00, 0,  0,  0);
        // alternation
        vecs[2]  = mk(0, 1, 8'hAA, 1, 8'h55, 1,  1, 0, 1, 8'hAA, 1,  1,  0);
        vecs[3]  = mk(0, 1, 8'hAA, 1, 8'h55, 1,  0, 1, 1, 8'h55, 0,  1,  1);
        vecs[4]  = mk(0, 1, 8'hAA, 1, 8'h55, 1,  1, 0, 1, 8'hAA, 1,  2,  1);
        vecs[5]  = mk(0, 1, 8'hAA, 1, 8'h55, 1,  0, 1, 1, 8'h55, 0,  2,  2);
        // load AA then stall for three cycles, then release
        vecs[6]  = mk(0, 1, 8'hAA, 1, 8'h55, 1,  1, 0, 1, 8'hAA, 1,  3,  2);
        vecs[7]  = mk(0, 1, 8'hAA, 1, 8'h55, 0,  0, 0, 1, 8'hAA, 1,  3,  2);
        vecs[8]  = mk(0, 1, 8'hAA, 1, 8'h55, 0,  0, 0, 1, 8'hAA, 1,  3,  2);
        vecs[9]  = mk(0, 1, 8'hAA, 1, 8'h55, 0,  0, 0, 1, 8'hAA, 1,  3,  2);
        vecs[10] = mk(0, 1, 8'hAA, 1, 8'h55, 1,  0, 1, 1, 8'h55, 0,  3,  3);
        // A alone leaves priority at B, then drain
        vecs[11] = mk(0, 1, 8'hAA, 0, 8'h55, 1,  1, 0, 1, 8'hAA, 1,  4,  3);
        vecs[12] = mk(0, 0, 8'hAA, 0, 8'h55, 1,  0, 0, 0, 8'hAA, 1,  4,  3);
        // B alone three beats; priority must end at A
        vecs[13] = mk(0, 0, 8'hAA, 1, 8'h0F, 1,  0, 1, 1, 8'h0F, 0,  4,  4);
        vecs[14] = mk(0, 0, 8'hAA, 1, 8'h0F, 1,  0, 1, 1, 8'h0F, 0,  4,  5);
        vecs[15] = mk(0, 0, 8'hAA, 1, 8'h0F, 1,  0, 1, 1, 8'h0F, 0,  4,  6);
        vecs[16] = mk(0, 1, 8'hAA, 1, 8'h55, 1,  1, 0, 1, 8'hAA, 1,  5,  6);

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data = 8'h00; b_data = 8'h00;

        for (int i = 0; i < 17; i++) apply(vecs[i], i);

        // Reset while a beat is stalled (priority is B at this point).
        apply(mk(0, 1, 8'hAA, 1, 8'h55, 0, 0, 0, 1, 8'hAA, 1, 5, 6), 100);
        apply(mk(1, 1, 8'hAA, 1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0, 0), 101);
        apply(mk(0, 1, 8'hAA, 1, 8'h55, 1, 1, 0, 1, 8'hAA, 1, 1, 0), 102);
        chk("sat_cnt_a", 102, {30'd0, s_cnt_a}, 32'd1);

        // Only A valid: the CNT_W=2 copy must stick at 3.
        begin
            logic [1:0] sat_exp[4];
            sat_exp[0] = 2'd2; sat_exp[1] = 2'd3; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;
            for (int k = 0; k < 4; k++) begin
                apply(mk(0, 1, 8'hC3, 0, 8'h00, 1, 1, 0, 1, 8'hC3, 1,
                         16'(k + 2), 0), 200 + k);
                chk("sat_cnt_a", 200 + k, {30'd0, s_cnt_a}, {30'd0, sat_exp[k]});
                chk("sat_cnt_b", 200 + k, {30'd0, s_cnt_b}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
